// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-side bundle for the hazard controller: ID operand/dest fields in, bypass selects, tags and stall out.
// All outputs are combinational from controller state and these ID fields; no handshake, stall is the only backpressure.
interface fwd_hazard_ctrl_if #(
  parameter int NREG_BITS = 4
);
  logic                 id_valid;
  logic [NREG_BITS-1:0] id_r2;
  logic [NREG_BITS-1:0] id_r3;
  logic                 id_r2_use;
  logic                 id_r3_use;
  logic [NREG_BITS-1:0] id_rd;
  logic                 id_we;
  logic                 id_load;
  logic                 id_mc;
  logic                 flush;

  logic [1:0]           sel_r2;
  logic [1:0]           sel_r3;
  logic [NREG_BITS-1:0] dest_ex;
  logic [NREG_BITS-1:0] dest_mem;
  logic [NREG_BITS-1:0] dest_wb;
  logic                 wen_ex;
  logic                 wen_mem;
  logic                 wen_wb;
  logic                 stall;
  logic                 mc_busy;

  modport master (
    output id_valid, id_r2, id_r3, id_r2_use, id_r3_use, id_rd, id_we, id_load, id_mc, flush,
    input  sel_r2, sel_r3, dest_ex, dest_mem, dest_wb, wen_ex, wen_mem, wen_wb, stall, mc_busy
  );

  modport slave (
    input  id_valid, id_r2, id_r3, id_r2_use, id_r3_use, id_rd, id_we, id_load, id_mc, flush,
    output sel_r2, sel_r3, dest_ex, dest_mem, dest_wb, wen_ex, wen_mem, wen_wb, stall, mc_busy
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding hazard controller: tracks EX/MEM/WB destinations, drives bypass selects, stalls decode.
// Selects/stall are same-cycle combinational; slots advance each clk, EX holds while a multi-cycle op is busy.
module fwd_hazard_ctrl #(
  parameter int NREG_BITS = 4,
  parameter int MC_LAT    = 3,
  parameter bit R0_ZERO   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  fwd_hazard_ctrl_if.slave hz
);
  typedef struct packed {
    logic                 valid;
    logic [NREG_BITS-1:0] rd;
    logic                 we;
    logic                 load;
    logic                 mc;
  } slot_t;

  localparam int          CNT_W   = 3;
  localparam logic [CNT_W-1:0] MC_INIT = CNT_W'(MC_LAT - 1);

  slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] mc_cnt_q, mc_cnt_d;

  function automatic logic src_hit(input logic use_s, input logic [NREG_BITS-1:0] src, input slot_t x);
    return use_s & x.valid & x.we & (x.rd == src) & ~(R0_ZERO & (src == '0));
  endfunction

  function automatic logic [1:0] pick(input logic h_ex, input logic h_mem, input logic h_wb);
    if (h_ex)       return 2'd1;
    else if (h_mem) return 2'd2;
    else if (h_wb)  return 2'd3;
    else            return 2'd0;
  endfunction

  logic  r2_ex, r2_mem, r2_wb, r3_ex, r3_mem, r3_wb;
  logic  load_use, busy, stall;
  slot_t id_slot;

  always_comb begin
    r2_ex    = src_hit(hz.id_r2_use, hz.id_r2, ex_q);
    r2_mem   = src_hit(hz.id_r2_use, hz.id_r2, mem_q);
    r2_wb    = src_hit(hz.id_r2_use, hz.id_r2, wb_q);
    r3_ex    = src_hit(hz.id_r3_use, hz.id_r3, ex_q);
    r3_mem   = src_hit(hz.id_r3_use, hz.id_r3, mem_q);
    r3_wb    = src_hit(hz.id_r3_use, hz.id_r3, wb_q);
    load_use = (r2_ex | r3_ex) & ex_q.load;
    busy     = (mc_cnt_q != '0);
    // A taken branch kills the instruction in ID, so it must never be held.
    stall    = hz.id_valid & (load_use | busy) & ~hz.flush;
    id_slot  = '{valid: hz.id_valid, rd: hz.id_rd, we: hz.id_we, load: hz.id_load, mc: hz.id_mc};
  end

  always_comb begin
    wb_d     = mem_q;
    mem_d    = ex_q;
    ex_d     = (hz.id_valid & ~stall) ? id_slot : '0;
    mc_cnt_d = mc_cnt_q;
    if (hz.flush) begin
      ex_d     = '0;
      mc_cnt_d = '0;
    end else if (busy) begin
      // Multi-cycle op keeps EX; nothing new may reach MEM behind it.
      ex_d     = ex_q;
      mem_d    = '0;
      mc_cnt_d = mc_cnt_q - 1'b1;
    end else if (ex_d.valid & ex_d.mc) begin
      mc_cnt_d = MC_INIT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      mc_cnt_q <= '0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  assign hz.sel_r2   = pick(r2_ex, r2_mem, r2_wb);
  assign hz.sel_r3   = pick(r3_ex, r3_mem, r3_wb);
  assign hz.dest_ex  = ex_q.rd;
  assign hz.dest_mem = mem_q.rd;
  assign hz.dest_wb  = wb_q.rd;
  assign hz.wen_ex   = ex_q.valid & ex_q.we;
  assign hz.wen_mem  = mem_q.valid & mem_q.we;
  assign hz.wen_wb   = wb_q.valid & wb_q.we;
  assign hz.stall    = stall;
  assign hz.mc_busy  = busy;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: directed hazard sequences then randomized decode traffic with resets.
// Driver pushes reference-model expectations; monitor pops and compares at the falling edge.
module tb_fwd_hazard_ctrl;
  localparam int NRB    = 4;
  localparam int MC_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.NREG_BITS(NRB)) hz ();

  fwd_hazard_ctrl #(.NREG_BITS(NRB), .MC_LAT(MC_LAT), .R0_ZERO(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  typedef struct packed {
    logic [1:0]     s2, s3;
    logic [NRB-1:0] dex, dmem, dwb;
    logic           wex, wmem, wwb, st, busy;
  } out_t;

  typedef struct {
    bit v;
    int rd;
    bit we, ld, mc;
  } ins_t;

  typedef struct {
    out_t  o;
    string tag;
  } exp_t;

  // Reference pipeline: index 0 = EX, 1 = MEM, 2 = WB; mc_left = remaining busy cycles.
  ins_t pipe[3];
  int   mc_left;
  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;
  bit   done   = 0;

  function automatic ins_t mk(bit v, int rd, bit we, bit ld, bit mc);
    ins_t i;
    i.v = v; i.rd = rd; i.we = we; i.ld = ld; i.mc = mc;
    return i;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) pipe[k] = mk(0, 0, 0, 0, 0);
    mc_left = 0;
  endfunction

  function automatic bool_prod(int k, bit u, int s);
    return u && pipe[k].v && pipe[k].we && pipe[k].rd == s && s != 0;
  endfunction

  function automatic logic [1:0] youngest(bit u, int s);
    for (int k = 0; k < 3; k++)
      if (bool_prod(k, u, s)) return 2'(k + 1);
    return 2'd0;
  endfunction

  function automatic out_t model_out(ins_t id, bit u2, int r2, bit u3, int r3, bit fl);
    out_t o;
    bit   lu;
    lu     = pipe[0].ld && (bool_prod(0, u2, r2) || bool_prod(0, u3, r3));
    o.s2   = youngest(u2, r2);
    o.s3   = youngest(u3, r3);
    o.dex  = NRB'(pipe[0].rd);
    o.dmem = NRB'(pipe[1].rd);
    o.dwb  = NRB'(pipe[2].rd);
    o.wex  = pipe[0].v && pipe[0].we;
    o.wmem = pipe[1].v && pipe[1].we;
    o.wwb  = pipe[2].v && pipe[2].we;
    o.busy = mc_left > 0;
    o.st   = id.v && !fl && (lu || mc_left > 0);
    return o;
  endfunction

  function automatic void model_step(ins_t id, bit stall, bit fl);
    ins_t bub;
    bub     = mk(0, 0, 0, 0, 0);
    pipe[2] = pipe[1];
    if (fl) begin
      pipe[1] = pipe[0];
      pipe[0] = bub;
      mc_left = 0;
    end else if (mc_left > 0) begin
      pipe[1] = bub;
      mc_left--;
    end else begin
      pipe[1] = pipe[0];
      pipe[0] = (id.v && !stall) ? id : bub;
      if (pipe[0].v && pipe[0].mc) mc_left = MC_LAT - 1;
    end
  endfunction

  task automatic cyc(ins_t id, bit u2, int r2, bit u3, int r3, bit fl, bit rv, string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = rv;
    hz.id_valid  = id.v;
    hz.id_rd     = NRB'(id.rd);
    hz.id_we     = id.we;
    hz.id_load   = id.ld;
    hz.id_mc     = id.mc;
    hz.id_r2_use = u2;
    hz.id_r2     = NRB'(r2);
    hz.id_r3_use = u3;
    hz.id_r3     = NRB'(r3);
    hz.flush     = fl;
    if (!rv) model_reset();
    e.o   = model_out(id, u2, r2, u3, r3, fl);
    e.tag = tag;
    sb.push_back(e);
    if (rv) model_step(id, e.o.st, fl);
  endtask

  task automatic nop(string tag);
    cyc(mk(0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 1, tag);
  endtask

  // Monitor: one comparison per scoreboard entry, at the falling edge.
  initial begin
    exp_t e;
    out_t a;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = '{hz.sel_r2, hz.sel_r3, hz.dest_ex, hz.dest_mem, hz.dest_wb,
              hz.wen_ex, hz.wen_mem, hz.wen_wb, hz.stall, hz.mc_busy};
        tests++;
        if (a !== e.o) begin
          failed++;
          $display("FAIL %s: got sel=%0d/%0d dest=%0d/%0d/%0d wen=%b%b%b stall=%b busy=%b, want sel=%0d/%0d dest=%0d/%0d/%0d wen=%b%b%b stall=%b busy=%b",
                   e.tag, a.s2, a.s3, a.dex, a.dmem, a.dwb, a.wex, a.wmem, a.wwb, a.st, a.busy,
                   e.o.s2, e.o.s3, e.o.dex, e.o.dmem, e.o.dwb, e.o.wex, e.o.wmem, e.o.wwb, e.o.st, e.o.busy);
        end
      end
    end
  end

  initial begin
    hz.id_valid = 0; hz.id_rd = 0; hz.id_we = 0; hz.id_load = 0; hz.id_mc = 0;
    hz.id_r2_use = 0; hz.id_r2 = 0; hz.id_r3_use = 0; hz.id_r3 = 0; hz.flush = 0;
    model_reset();

    cyc(mk(1, 3, 1, 0, 0), 1, 3, 1, 3, 0, 0, "reset_state");
    cyc(mk(0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, "reset_hold");

    // ADD r1 then consumers at distance 1, 2, 3
    cyc(mk(1, 1, 1, 0, 0), 0, 0, 0, 0, 0, 1, "add_r1");
    cyc(mk(1, 2, 1, 0, 0), 1, 1, 0, 0, 0, 1, "fwd_ex");
    cyc(mk(1, 1, 1, 0, 0), 0, 0, 0, 0, 0, 1, "add_r1_b");
    nop("nop1");
    cyc(mk(1, 2, 1, 0, 0), 1, 1, 0, 0, 0, 1, "fwd_mem");
    cyc(mk(1, 1, 1, 0, 0), 0, 0, 0, 0, 0, 1, "add_r1_c");
    nop("nop2");
    nop("nop3");
    cyc(mk(1, 2, 1, 0, 0), 1, 1, 0, 0, 0, 1, "fwd_wb");

    // Load-use: one stall, then MEM forward
    cyc(mk(1, 5, 1, 1, 0), 0, 0, 0, 0, 0, 1, "load_r5");
    cyc(mk(1, 6, 1, 0, 0), 0, 0, 1, 5, 0, 1, "load_use_stall");
    cyc(mk(1, 6, 1, 0, 0), 0, 0, 1, 5, 0, 1, "load_use_fwd");

    // Multi-cycle op: two stall cycles then EX forward
    cyc(mk(1, 7, 1, 0, 1), 0, 0, 0, 0, 0, 1, "mc_r7");
    repeat (3) cyc(mk(1, 8, 1, 0, 0), 1, 7, 0, 0, 0, 1, "mc_use");
    nop("mc_drain");

    // r0 never forwards or stalls
    cyc(mk(1, 0, 1, 1, 0), 0, 0, 0, 0, 0, 1, "load_r0");
    cyc(mk(1, 9, 1, 0, 0), 1, 0, 1, 0, 0, 1, "r0_use");

    // Load-use with flush: flush wins
    cyc(mk(1, 5, 1, 1, 0), 0, 0, 0, 0, 0, 1, "load_r5_f");
    cyc(mk(1, 6, 1, 0, 0), 1, 5, 0, 0, 1, 1, "flush_vs_stall");
    nop("after_flush");

    // Reset in the middle of an MC stall
    cyc(mk(1, 7, 1, 0, 1), 0, 0, 0, 0, 0, 1, "mc_r7_b");
    cyc(mk(1, 8, 1, 0, 0), 1, 7, 0, 0, 0, 1, "mc_stall_b");
    cyc(mk(1, 8, 1, 0, 0), 1, 7, 0, 0, 0, 0, "rst_mid_mc");
    cyc(mk(1, 8, 1, 0, 0), 1, 7, 0, 0, 0, 1, "post_rst");
    cyc(mk(1, 9, 1, 0, 0), 1, 8, 0, 0, 0, 1, "post_rst_fwd");

    // Randomized traffic on a small tag set to provoke hazards
    for (int n = 0; n < 600; n++) begin
      bit ld, mc;
      ld = ($urandom_range(0, 3) == 0);
      mc = !ld && ($urandom_range(0, 5) == 0);
      cyc(mk(($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 1), ld, mc),
          $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 63) != 0), "random");
    end

    for (int w = 0; w < 20 && sb.size() > 0; w++) @(posedge clk);
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
